// File: rtl/valu_seq.sv
// valu_seq: handshaked vector ALU placed between the vector register-file read
// stage and writeback.
//   Elementwise add/sub/mul (vector-vector or vector-scalar) finish in one cycle.
//   min/max reductions take one element per cycle, starting from the scalar seed.
// Ports:
//   clk, rst_n                 clock and synchronous active-low reset
//   in_valid/in_ready          request handshake; a request is accepted only in IDLE
//   valu_op, SEW, red_signed   opcode, element width, signedness of min/max
//   reg_in1, reg_in2           vector operands; reductions walk reg_in1
//   reg_scalar_in              scalar operand / reduction seed (low SEW bits)
//   out_valid/out_ready        result handshake
//   reg_dest, out_err          result and illegal-SEW flag, held while out_valid
//   busy                       high while an operation is in flight or waiting
module valu_seq #(
  parameter int VLEN    = 128,
  parameter int SEW_MAX = 128
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      valu_op,
  input  logic [7:0]      SEW,
  input  logic            red_signed,
  input  logic [VLEN-1:0] reg_in1,
  input  logic [VLEN-1:0] reg_in2,
  input  logic [VLEN-1:0] reg_scalar_in,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [VLEN-1:0] reg_dest,
  output logic            out_err,
  output logic            busy
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam int IW = $clog2(VLEN / 8);

  state_t          state_q, state_d;
  logic [VLEN-1:0] dest_q, dest_d;
  logic            err_q, err_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [VLEN-1:0] acc_q, acc_d;
  logic [VLEN-1:0] vec_q, vec_d;
  logic [7:0]      sew_q, sew_d;
  logic            sgn_q, sgn_d;
  logic            max_q, max_d;

  function automatic logic sew_legal(input logic [7:0] s);
    return ((s == 8'd8) || (s == 8'd16) || (s == 8'd32) || (s == 8'd64) ||
            (s == 8'd128)) && (int'(s) <= SEW_MAX);
  endfunction

  // Low s bits set; s = VLEN wraps through the extra bit to all ones.
  function automatic logic [VLEN-1:0] sew_mask(input logic [7:0] s);
    logic [VLEN:0] t;
    t = ({{VLEN{1'b0}}, 1'b1} << s) - {{VLEN{1'b0}}, 1'b1};
    return t[VLEN-1:0];
  endfunction

  function automatic logic [2:0] sew_sel(input logic [7:0] s);
    case (s)
      8'd16:   return 3'd1;
      8'd32:   return 3'd2;
      8'd64:   return 3'd3;
      8'd128:  return 3'd4;
      default: return 3'd0;
    endcase
  endfunction

  function automatic logic [IW-1:0] last_idx(input logic [7:0] s);
    case (s)
      8'd16:   return IW'(VLEN / 16 - 1);
      8'd32:   return IW'(VLEN / 32 - 1);
      8'd64:   return IW'(VLEN / 64 - 1);
      8'd128:  return IW'(VLEN / 128 - 1);
      default: return IW'(VLEN / 8 - 1);
    endcase
  endfunction

  // One full-width elementwise result per element width; lanes never carry
  // into each other because each lane is its own W-bit expression.
  logic [4:0][VLEN-1:0] ew_res;

  for (genvar gw = 0; gw < 5; gw++) begin : g_w
    localparam int W = 8 << gw;
    if (W <= SEW_MAX && W <= VLEN) begin : g_on
      for (genvar ge = 0; ge < VLEN / W; ge++) begin : g_e
        logic [W-1:0] a, b;
        assign a = reg_in1[ge*W +: W];
        assign b = valu_op[0] ? reg_scalar_in[W-1:0] : reg_in2[ge*W +: W];
        assign ew_res[gw][ge*W +: W] = valu_op[2] ? a * b : (valu_op[1] ? a - b : a + b);
      end
    end else begin : g_off
      assign ew_res[gw] = '0;
    end
  end

  // Reduction step. Signed order is obtained by flipping the element sign bit
  // and then comparing unsigned.
  logic [VLEN-1:0] msk, msb, elem, key_a, key_e, acc_nxt;
  logic            take_e;

  always_comb begin
    msk     = sew_mask(sew_q);
    msb     = msk ^ (msk >> 1);
    elem    = (vec_q >> (int'(idx_q) * int'(sew_q))) & msk;
    key_a   = acc_q ^ (sgn_q ? msb : '0);
    key_e   = elem ^ (sgn_q ? msb : '0);
    take_e  = max_q ? (key_e > key_a) : (key_e < key_a);
    acc_nxt = take_e ? elem : acc_q;
  end

  always_comb begin
    state_d = state_q;
    dest_d  = dest_q;
    err_d   = err_q;
    idx_d   = idx_q;
    acc_d   = acc_q;
    vec_d   = vec_q;
    sew_d   = sew_q;
    sgn_d   = sgn_q;
    max_d   = max_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (!sew_legal(SEW)) begin
            dest_d  = '0;
            err_d   = 1'b1;
            state_d = DONE;
          end else if (valu_op[2:1] != 2'b11) begin
            dest_d  = ew_res[sew_sel(SEW)];
            err_d   = 1'b0;
            state_d = DONE;
          end else begin
            acc_d   = reg_scalar_in & sew_mask(SEW);
            vec_d   = reg_in1;
            sew_d   = SEW;
            sgn_d   = red_signed;
            max_d   = valu_op[0];
            idx_d   = '0;
            err_d   = 1'b0;
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        acc_d = acc_nxt;
        idx_d = idx_q + 1'b1;
        if (idx_q == last_idx(sew_q)) begin
          dest_d  = acc_nxt;
          idx_d   = '0;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          err_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      dest_q  <= '0;
      err_q   <= 1'b0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      dest_q  <= dest_d;
      err_q   <= err_d;
      idx_q   <= idx_d;
    end
  end

  // Operand latches are only meaningful in BUSY, so they need no reset.
  always_ff @(posedge clk) begin
    acc_q <= acc_d;
    vec_q <= vec_d;
    sew_q <= sew_d;
    sgn_q <= sgn_d;
    max_q <= max_d;
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign reg_dest  = dest_q;
  assign out_err   = err_q;

endmodule

// File: tb/tb_valu_seq.sv
// Directed bench for valu_seq at VLEN = 128, SEW_MAX = 128.
module tb_valu_seq;
  logic         clk = 1'b0;
  logic         rst_n, in_valid, in_ready, red_signed;
  logic [2:0]   valu_op;
  logic [7:0]   SEW;
  logic [127:0] reg_in1, reg_in2, reg_scalar_in, reg_dest;
  logic         out_valid, out_ready, out_err, busy;

  int total = 0;
  int bad   = 0;
  int lat;
  bit ir_seen;

  always #5 clk = ~clk;

  valu_seq #(.VLEN(128), .SEW_MAX(128)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .valu_op(valu_op), .SEW(SEW), .red_signed(red_signed),
    .reg_in1(reg_in1), .reg_in2(reg_in2), .reg_scalar_in(reg_scalar_in),
    .out_valid(out_valid), .out_ready(out_ready), .reg_dest(reg_dest),
    .out_err(out_err), .busy(busy)
  );

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Accept one request, then scramble the inputs to show they were latched.
  task automatic issue(input logic [2:0] op, input logic [7:0] sew, input logic sg,
                       input logic [127:0] a, input logic [127:0] b, input logic [127:0] s);
    valu_op = op; SEW = sew; red_signed = sg;
    reg_in1 = a; reg_in2 = b; reg_scalar_in = s;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    reg_in1 = ~a; reg_in2 = ~b; reg_scalar_in = ~s; red_signed = ~sg;
  endtask

  // lat = 1 means out_valid is up in the cycle right after the accept edge.
  task automatic wait_valid(output int l, output bit irs);
    l = 1; irs = 1'b0;
    while (!out_valid && l < 200) begin
      if (in_ready) irs = 1'b1;
      @(posedge clk); #1;
      l++;
    end
  endtask

  task automatic release_out(input string tag);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, "_ovld_after"}, out_valid, 0);
    chk({tag, "_irdy_after"}, in_ready, 1);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; valu_op = 3'd0; SEW = 8'd8;
    red_signed = 1'b0; reg_in1 = '0; reg_in2 = '0; reg_scalar_in = '0;
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    chk("rst_irdy", in_ready, 1);
    chk("rst_ovld", out_valid, 0);
    chk("rst_dest", reg_dest, 0);
    chk("rst_err",  out_err, 0);
    chk("rst_busy", busy, 0);

    // vv add, SEW 8: 0xFF + 0x02 wraps to 0x01 per byte
    issue(3'b000, 8'd8, 1'b0, {16{8'hFF}}, {16{8'h02}}, '0);
    wait_valid(lat, ir_seen);
    chk("add8_lat",  lat, 1);
    chk("add8_dest", reg_dest, {16{8'h01}});
    chk("add8_err",  out_err, 0);
    release_out("add8");

    // vx mul, SEW 16: 3 * 0xFFFF -> low half 0xFFFD
    issue(3'b101, 8'd16, 1'b0, {8{16'h0003}}, '0, 128'hFFFF);
    wait_valid(lat, ir_seen);
    chk("mul16_lat",  lat, 1);
    chk("mul16_dest", reg_dest, {8{16'hFFFD}});
    release_out("mul16");

    // signed redmin, SEW 8, seed 0 -> 0x80
    issue(3'b110, 8'd8, 1'b1, 128'h01010101_01010101_01010101_017F1080, '0, '0);
    wait_valid(lat, ir_seen);
    chk("smin8_lat",  lat, 17);
    chk("smin8_dest", reg_dest, 128'h80);
    release_out("smin8");

    // unsigned redmin, same data -> seed 0 survives
    issue(3'b110, 8'd8, 1'b0, 128'h01010101_01010101_01010101_017F1080, '0, '0);
    wait_valid(lat, ir_seen);
    chk("umin8_lat",  lat, 17);
    chk("umin8_dest", reg_dest, 128'h0);
    release_out("umin8");

    // unsigned redmax, SEW 32, {5,9,2,7}, seed 3 -> 9
    issue(3'b111, 8'd32, 1'b0, 128'h00000007_00000002_00000009_00000005, '0, 128'd3);
    wait_valid(lat, ir_seen);
    chk("umax32_lat",  lat, 5);
    chk("umax32_dest", reg_dest, 128'd9);
    chk("umax32_irdy_low", ir_seen, 0);
    release_out("umax32");

    // signed redmax, SEW 128: one element (-5), seed 3 -> 3
    issue(3'b111, 8'd128, 1'b1, {{124{1'b1}}, 4'hB}, '0, 128'd3);
    wait_valid(lat, ir_seen);
    chk("smax128_lat",  lat, 2);
    chk("smax128_dest", reg_dest, 128'd3);
    release_out("smax128");

    // vv sub, SEW 64, held under back-pressure for 5 cycles
    issue(3'b010, 8'd64, 1'b0, {64'd10, 64'd3}, {64'd4, 64'd5}, '0);
    wait_valid(lat, ir_seen);
    chk("sub64_lat", lat, 1);
    for (int i = 0; i < 5; i++) begin
      chk("hold_dest", reg_dest, {64'd6, 64'hFFFF_FFFF_FFFF_FFFE});
      chk("hold_ovld", out_valid, 1);
      chk("hold_irdy", in_ready, 0);
      @(posedge clk); #1;
    end
    release_out("sub64");

    // illegal SEW 24 -> error, zero result, latency 1
    issue(3'b000, 8'd24, 1'b0, {16{8'h11}}, {16{8'h22}}, '0);
    wait_valid(lat, ir_seen);
    chk("sew24_lat",  lat, 1);
    chk("sew24_err",  out_err, 1);
    chk("sew24_dest", reg_dest, 0);
    release_out("sew24");
    chk("sew24_err_clr", out_err, 0);

    // reset in the middle of a SEW 8 reduction
    issue(3'b111, 8'd8, 1'b0, {16{8'h42}}, '0, '0);
    @(posedge clk); @(posedge clk); #1;
    chk("abort_busy", busy, 1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("abort_irdy", in_ready, 1);
    chk("abort_ovld", out_valid, 0);
    chk("abort_dest", reg_dest, 0);
    chk("abort_busy_low", busy, 0);
    repeat (20) @(posedge clk);
    #1;
    chk("abort_no_result", out_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
